present_engine: RTL and testbench

//  Parametrised iterative PRESENT block-cipher core, the successor to the fixed 80-bit encrypt-only core.
//  - On-the-fly key schedule: no precomputed round-key array.
//  - 80- or 128-bit keys; valid/ready handshakes on input and output.
//  - Optional decryption mode.
//  - Sits between the crypto command front-end and the output buffer; one 64-bit block in flight at a time.

---
 rtl/present_pkg.sv | 56 +++++
 rtl/present_key_sched.sv | 70 +++++++
 rtl/present_engine.sv | 140 ++++++++++++++
 tb/tb_present_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared types, S-box tables and block-layer functions for the PRESENT engine.
// The inverse-path states exist only when PRESENT_DECRYPT_EN is defined.
package present_pkg;

  localparam int BLOCK_SIZE = 64;

`ifdef PRESENT_DECRYPT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_ENC, ST_KEYFWD, ST_DEC, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_DONE} state_t;
`endif

  // Nibble i of each table holds S(i) / S^-1(i).
  localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
    return INV_SBOX[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] sbox_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < BLOCK_SIZE / 4; i++) r[4*i +: 4] = sbox4(s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] inv_sbox_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < BLOCK_SIZE / 4; i++) r[4*i +: 4] = inv_sbox4(s[4*i +: 4]);
    return r;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 is fixed.
  function automatic logic [BLOCK_SIZE-1:0] p_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    r = '0;
    r[63] = s[63];
    for (int i = 0; i < 63; i++) r[(16 * i) % 63] = s[i];
    return r;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] inv_p_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    r = '0;
    r[63] = s[63];
    for (int i = 0; i < 63; i++) r[i] = s[(16 * i) % 63];
    return r;
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// On-the-fly PRESENT key schedule: key register stepped forward or backward per round.
// The backward step is built only when PRESENT_DECRYPT_EN is defined.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                load,
  input  logic [KEY_SIZE-1:0] load_key,
  input  logic                step,
  input  logic                inv,
  input  logic [4:0]          round,
  output logic [63:0]         cur_key,
  output logic [63:0]         nxt_key
);

  localparam int RC_LSB = (KEY_SIZE == 128) ? 62 : 15;

  if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
    $error("present_key_sched: KEY_SIZE must be 80 or 128");
  end

  logic [KEY_SIZE-1:0] key_q;
  logic [KEY_SIZE-1:0] upd_key;

  function automatic logic [KEY_SIZE-1:0] fwd_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0] rc);
    logic [KEY_SIZE-1:0] t;
    t = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    t[KEY_SIZE-1 -: 4] = sbox4(t[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) t[KEY_SIZE-5 -: 4] = sbox4(t[KEY_SIZE-5 -: 4]);
    t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ rc;
    return t;
  endfunction

`ifdef PRESENT_DECRYPT_EN
  // Undo the forward step in reverse order: counter, S-box, then rotate right 61.
  function automatic logic [KEY_SIZE-1:0] inv_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0] rc);
    logic [KEY_SIZE-1:0] t;
    t = k;
    t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ rc;
    t[KEY_SIZE-1 -: 4] = inv_sbox4(t[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) t[KEY_SIZE-5 -: 4] = inv_sbox4(t[KEY_SIZE-5 -: 4]);
    return {t[60:0], t[KEY_SIZE-1:61]};
  endfunction

  assign upd_key = inv ? inv_update(key_q, round) : fwd_update(key_q, round);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign upd_key    = fwd_update(key_q, round);
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      key_q <= '0;
    end else if (load) begin
      key_q <= load_key;
    end else if (step) begin
      key_q <= upd_key;
    end
  end

  assign cur_key = key_q[KEY_SIZE-1 -: 64];
  assign nxt_key = upd_key[KEY_SIZE-1 -: 64];

endmodule

// File: rtl/present_engine.sv
// Iterative PRESENT cipher core, one block in flight, valid/ready on both sides.
// Define PRESENT_DECRYPT_EN to build the KEYFWD/DEC decryption path.
module present_engine
  import present_pkg::*;
#(
  parameter int KEY_SIZE   = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [KEY_SIZE-1:0]   in_key,
  input  logic [BLOCK_SIZE-1:0] in_text,
  input  logic                  in_decrypt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] out_text,
  output logic                  busy
);

  localparam int RW = $clog2(NUM_ROUNDS + 2);
  localparam logic [RW-1:0] LAST_ROUND  = RW'(NUM_ROUNDS);
  localparam logic [RW-1:0] FIRST_ROUND = RW'(1);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 62) begin : g_bad_rounds
    $error("present_engine: NUM_ROUNDS must be in 1..62");
  end

  state_t                  state_q;
  logic [RW-1:0]           round_q;
  logic [BLOCK_SIZE-1:0]   text_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    accept;
  logic                    key_step;
  logic                    key_inv;
  logic [63:0]             cur_key;
  logic [63:0]             nxt_key;
  logic [BLOCK_SIZE-1:0]   enc_round;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign enc_round = p_layer(sbox_layer(text_q ^ cur_key));

`ifdef PRESENT_DECRYPT_EN
  logic [BLOCK_SIZE-1:0] dec_round;
  assign dec_round = inv_sbox_layer(inv_p_layer(text_q ^ cur_key));
  assign key_step  = (state_q == ST_ENC) || (state_q == ST_KEYFWD) || (state_q == ST_DEC);
  assign key_inv   = (state_q == ST_DEC);
`else
  logic unused_decrypt;
  assign unused_decrypt = in_decrypt;
  assign key_step       = (state_q == ST_ENC);
  assign key_inv        = 1'b0;
`endif

  present_key_sched #(
    .KEY_SIZE (KEY_SIZE)
  ) u_key_sched (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (accept),
    .load_key (in_key),
    .step     (key_step),
    .inv      (key_inv),
    .round    (5'(round_q)),
    .cur_key  (cur_key),
    .nxt_key  (nxt_key)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      text_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      // Acceptance from IDLE or straight out of DONE (no bubble).
      text_q      <= in_text;
      round_q     <= FIRST_ROUND;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
`ifdef PRESENT_DECRYPT_EN
      state_q     <= in_decrypt ? ST_KEYFWD : ST_ENC;
`else
      state_q     <= ST_ENC;
`endif
    end else begin
      case (state_q)
        ST_ENC: begin
          if (round_q == LAST_ROUND) begin
            // Final whitening with the key produced by this same step.
            text_q      <= enc_round ^ nxt_key;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            text_q  <= enc_round;
            round_q <= round_q + FIRST_ROUND;
          end
        end
`ifdef PRESENT_DECRYPT_EN
        ST_KEYFWD: begin
          // Counter stays at NUM_ROUNDS so DEC starts from the top round.
          if (round_q == LAST_ROUND) begin
            state_q <= ST_DEC;
          end else begin
            round_q <= round_q + FIRST_ROUND;
          end
        end
        ST_DEC: begin
          if (round_q == FIRST_ROUND) begin
            text_q      <= dec_round ^ nxt_key;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            text_q  <= dec_round;
            round_q <= round_q - FIRST_ROUND;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_text  = text_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_present_engine.sv
// Directed bench for present_engine: 80-bit and 128-bit instances share the request stream.
module tb_present_engine;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         in_valid;
  logic         in_decrypt;
  logic         out_ready;
  logic [79:0]  in_key;
  logic [127:0] key128;
  logic [63:0]  in_text;
  logic         in_ready, out_valid, busy;
  logic [63:0]  out_text;
  logic         in_ready_w, out_valid_w, busy_w;
  logic [63:0]  out_text_w;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_w;

  always #5 Clock = ~Clock;

  present_engine #(.KEY_SIZE(80), .NUM_ROUNDS(31)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_text(in_text), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .busy(busy)
  );

  present_engine #(.KEY_SIZE(128), .NUM_ROUNDS(31)) dut_w (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_key(key128), .in_text(in_text), .in_decrypt(in_decrypt),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_text(out_text_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_sb(input logic [3:0] n);
    case (n)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Textbook PRESENT-80 encryption with a precomputed round-key list.
  function automatic logic [63:0] ref_enc80(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] rk [1:32];
    logic [63:0] s, t;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = ref_sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_sb(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
    end
    return s ^ rk[32];
  endfunction

  // One request from IDLE; inputs are scrambled right after acceptance.
  task automatic run_block(input logic [79:0] key, input logic [63:0] txt, input logic dec,
                           input logic [63:0] exp, input int exp_lat, input string tag);
    int lat;
    @(negedge Clock);
    in_key = key; in_text = txt; in_decrypt = dec; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0; in_key = ~key; in_text = ~txt; in_decrypt = ~dec;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge Clock); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, out_text, exp);
    last_w = out_text_w;
    @(posedge Clock); #1;
  endtask

  initial begin
    int lat;
    logic [63:0] exp_dec;
    int lat_dec;
    Reset = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b1;
    in_key = '0; key128 = '0; in_text = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_text", out_text, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    Reset = 1'b1;

    run_block(80'h0, 64'h0, 1'b0, 64'h5579C1387B228445, 31, "enc_k0_p0");
    check("enc128_k0_p0", last_w, 64'h96DB702A2E6900AF);
    run_block({80{1'b1}}, {64{1'b1}}, 1'b0, 64'h3333DCD3213210D2, 31, "enc_kF_pF");
    run_block(80'h0, {64{1'b1}}, 1'b0, 64'hA112FFC72F68417B, 31, "enc_k0_pF");

`ifdef PRESENT_DECRYPT_EN
    exp_dec = 64'h0;
    lat_dec = 62;
`else
    exp_dec = ref_enc80({80{1'b1}}, 64'hE72C46C0F5945049);
    lat_dec = 31;
`endif
    run_block({80{1'b1}}, 64'hE72C46C0F5945049, 1'b1, exp_dec, lat_dec, "dec_kF");

    // Backpressure, then back-to-back acceptance out of DONE.
    @(negedge Clock);
    in_key = '0; in_text = '0; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge Clock); #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd31);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("bp_hold_text", out_text, 64'h5579C1387B228445);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    @(negedge Clock);
    out_ready = 1'b1; in_valid = 1'b1; in_key = {80{1'b1}}; in_text = {64{1'b1}};
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge Clock); #1;
    in_valid = 1'b0; in_key = '0; in_text = '0;
    check("b2b_out_valid_drop", 64'(out_valid), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge Clock); #1;
      lat++;
    end
    check("b2b_lat", 64'(lat), 64'd31);
    check("b2b_text", out_text, 64'h3333DCD3213210D2);
    @(posedge Clock); #1;

    // Reset in the middle of a block.
    @(negedge Clock);
    in_key = '0; in_text = {64{1'b1}}; in_valid = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_text", out_text, 64'd0);
    Reset = 1'b1;
    run_block(80'h0, {64{1'b1}}, 1'b0, 64'hA112FFC72F68417B, 31, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
